pc_seq_ctrl: RTL and testbench

Multi-cycle fetch/execute sequencer for the MIPS core. It decides, each clock, the pc_inc_type applied to the PC register. That register updates every clock, so the controller holds it with the HOLD encoding except on the single retire cycle of each instruction. It handshakes with instruction memory and the execute stage, and sequences fetch, decode, execute and PC update.

---
 rtl/pc_seq_ctrl_pkg.sv | 44 ++++
 rtl/pc_seq_timer.sv | 34 +++
 rtl/pc_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared constants for the fetch/execute sequencer: PC increment codes, decoded instruction
// classes, FSM state encodings and timer helpers.
package pc_seq_ctrl_pkg;

  localparam int unsigned TimerW = 8;

  // PC increment selection, also decoded by the PC register
  localparam logic [1:0] PcIncNormal = 2'd0;
  localparam logic [1:0] PcIncBranch = 2'd1;
  localparam logic [1:0] PcIncJump   = 2'd2;
  localparam logic [1:0] PcIncHold   = 2'd3;

  localparam logic [1:0] InstrClassSeq    = 2'd0;
  localparam logic [1:0] InstrClassBranch = 2'd1;
  localparam logic [1:0] InstrClassJump   = 2'd2;
  localparam logic [1:0] InstrClassHalt   = 2'd3;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StUpdate = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;
  localparam logic [2:0] StErr    = 3'd6;

  function automatic logic [1:0] class_to_inc(input logic [1:0] cls);
    logic [1:0] inc;
    unique case (cls)
      InstrClassSeq:    inc = PcIncNormal;
      InstrClassBranch: inc = PcIncBranch;
      InstrClassJump:   inc = PcIncJump;
      default:          inc = PcIncHold;
    endcase
    return inc;
  endfunction

  // A timeout of N cycles fires on the cycle where N-1 idle cycles have already been counted
  function automatic logic [TimerW-1:0] timer_limit(input int unsigned cycles);
    if (cycles <= 1) return '0;
    if (cycles >= 255) return 8'd254;
    return TimerW'(cycles - 1);
  endfunction

endpackage

// File: rtl/pc_seq_timer.sv
// 8-bit saturating wait counter with synchronous clear, count enable and compare-equal flag.
module pc_seq_timer
  import pc_seq_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [TimerW-1:0] limit_i,
  output logic              eq_o
);

  logic [TimerW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {TimerW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_o = (cnt_q == limit_i);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/update sequencer driving the PC increment select.
// Optional PC_SEQ_PERF_EN adds retired/taken instruction counters.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_TIMEOUT = 16,
  parameter int unsigned EXEC_MAX     = 8
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        imem_ack_i,
  input  logic [1:0]  instr_class_i,
  input  logic        exec_done_i,
  input  logic        alu_branch_result_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic        instr_latch_en_o,
  output logic        exec_start_o,
  output logic [1:0]  pc_inc_type_o,
  output logic        halted_o,
  output logic        fetch_err_o,
  output logic        exec_err_o,
  output logic        alu_branch_result_q_o
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] retired_cnt_o,
  output logic [31:0] taken_cnt_o
`endif
);

  localparam logic [TimerW-1:0] FetchLimit = timer_limit(IMEM_TIMEOUT);
  localparam logic [TimerW-1:0] ExecLimit  = timer_limit(EXEC_MAX);

  logic [2:0] state_q, state_d;
  logic [1:0] class_q, class_d;
  logic       abr_q, abr_d;
  logic       fetch_err_q, fetch_err_d;
  logic       exec_err_q, exec_err_d;

  logic fetch_clr, fetch_en, fetch_eq;
  logic exec_clr, exec_en, exec_eq;
  logic retire;

  // Timers idle at zero outside their own state; stall freezes them in place
  assign fetch_clr = (state_q != StFetch);
  assign fetch_en  = (state_q == StFetch) && !stall_i && !imem_ack_i;
  assign exec_clr  = (state_q != StExec);
  assign exec_en   = (state_q == StExec) && !stall_i && !exec_done_i;

  pc_seq_timer u_fetch_timer (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clr_i   (fetch_clr),
    .en_i    (fetch_en),
    .limit_i (FetchLimit),
    .eq_o    (fetch_eq)
  );

  pc_seq_timer u_exec_timer (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clr_i   (exec_clr),
    .en_i    (exec_en),
    .limit_i (ExecLimit),
    .eq_o    (exec_eq)
  );

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    abr_d       = abr_q;
    fetch_err_d = fetch_err_q;
    exec_err_d  = exec_err_q;
    if (!stall_i) begin
      unique case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          // ack wins over a timeout landing on the same cycle
          if (imem_ack_i) begin
            state_d = StDecode;
          end else if (fetch_eq) begin
            state_d     = StErr;
            fetch_err_d = 1'b1;
          end
        end
        StDecode: begin
          class_d = instr_class_i;
          state_d = (instr_class_i == InstrClassHalt) ? StHalt : StExec;
        end
        StExec: begin
          if (exec_done_i) begin
            abr_d   = alu_branch_result_i;
            state_d = StUpdate;
          end else if (exec_eq) begin
            state_d    = StErr;
            exec_err_d = 1'b1;
          end
        end
        StUpdate: state_d = StFetch;
        StHalt:   state_d = StHalt;
        StErr:    state_d = StErr;
        default:  state_d = StErr;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      class_q     <= InstrClassSeq;
      abr_q       <= 1'b0;
      fetch_err_q <= 1'b0;
      exec_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      abr_q       <= abr_d;
      fetch_err_q <= fetch_err_d;
      exec_err_q  <= exec_err_d;
    end
  end

  // The single retire cycle; a stalled UPDATE defers the PC advance
  assign retire = (state_q == StUpdate) && !stall_i;

  always_comb begin
    imem_req_o            = (state_q == StFetch);
    instr_latch_en_o      = (state_q == StFetch) && imem_ack_i && !stall_i;
    exec_start_o          = (state_q == StDecode) && !stall_i &&
                            (instr_class_i != InstrClassHalt);
    pc_inc_type_o         = retire ? class_to_inc(class_q) : PcIncHold;
    halted_o              = (state_q == StHalt);
    fetch_err_o           = fetch_err_q;
    exec_err_o            = exec_err_q;
    alu_branch_result_q_o = abr_q;
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] taken_q, taken_d;
  logic        taken_evt;

  assign taken_evt = retire && (((class_q == InstrClassBranch) && abr_q) ||
                                (class_q == InstrClassJump));

  always_comb begin
    retired_d = retire ? retired_q + 32'd1 : retired_q;
    taken_d   = taken_evt ? taken_q + 32'd1 : taken_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign retired_cnt_o = retired_q;
  assign taken_cnt_o   = taken_q;
`endif

`ifndef SYNTHESIS
  a_inc_only_on_retire : assert property (@(posedge clk_i) disable iff (!rst_n)
    (pc_inc_type_o != PcIncHold) |-> retire);
  a_latch_with_req : assert property (@(posedge clk_i) disable iff (!rst_n)
    instr_latch_en_o |-> imem_req_o);
  a_err_terminal : assert property (@(posedge clk_i) disable iff (!rst_n)
    (state_q == StErr) |=> (state_q == StErr));
  a_halt_terminal : assert property (@(posedge clk_i) disable iff (!rst_n)
    (state_q == StHalt) |=> (state_q == StHalt));
  a_legal_state : assert property (@(posedge clk_i) disable iff (!rst_n)
    state_q != 3'd7);
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: a cycle-by-cycle vector table plus hand-written
// sequences for timeouts, stalls, HALT and asynchronous reset.
module tb_pc_seq_ctrl;
  import pc_seq_ctrl_pkg::*;

  localparam int unsigned ImemTimeout = 16;
  localparam int unsigned ExecMax     = 8;
  localparam logic [31:0] PcStart     = 32'h0040_0000;
  localparam logic [31:0] BrAddr      = 32'h0040_0100;
  localparam logic [31:0] JmpAddr     = 32'h0040_0020;
  localparam logic [1:0]  H = PcIncHold, N = PcIncNormal, B = PcIncBranch, J = PcIncJump;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_ack = 1'b0;
  logic [1:0] instr_class = 2'd0;
  logic       exec_done = 1'b0;
  logic       alu_br = 1'b0;
  logic       stall = 1'b0;
  logic       imem_req, instr_latch_en, exec_start, halted, fetch_err, exec_err, abr_q;
  logic [1:0] pc_inc_type;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] retired_cnt, taken_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  pc_seq_ctrl #(
    .IMEM_TIMEOUT (ImemTimeout),
    .EXEC_MAX     (ExecMax)
  ) dut (
    .clk_i                 (clk_i),
    .rst_n                 (rst_n),
    .imem_ack_i            (imem_ack),
    .instr_class_i         (instr_class),
    .exec_done_i           (exec_done),
    .alu_branch_result_i   (alu_br),
    .stall_i               (stall),
    .imem_req_o            (imem_req),
    .instr_latch_en_o      (instr_latch_en),
    .exec_start_o          (exec_start),
    .pc_inc_type_o         (pc_inc_type),
    .halted_o              (halted),
    .fetch_err_o           (fetch_err),
    .exec_err_o            (exec_err),
    .alu_branch_result_q_o (abr_q)
`ifdef PC_SEQ_PERF_EN
    ,
    .retired_cnt_o         (retired_cnt),
    .taken_cnt_o           (taken_cnt)
`endif
  );

  // Reference PC register driven by the controller's pc_inc_type
  logic [31:0] pc;
  logic        br_taken;
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= PcStart;
      br_taken <= 1'b0;
    end else begin
      if (exec_done && !stall) br_taken <= alu_br;
      case (pc_inc_type)
        PcIncNormal: pc <= pc + 32'd4;
        PcIncBranch: pc <= br_taken ? BrAddr : pc + 32'd4;
        PcIncJump:   pc <= JmpAddr;
        default:     pc <= pc;
      endcase
    end
  end

  typedef struct {
    logic       st;
    logic       ack;
    logic [1:0] cls;
    logic       done;
    logic       abr;
    logic [8:0] exp;
    logic [31:0] pc;
  } vec_t;

  vec_t vq[$];

  // {req, latch, start, inc[1:0], halted, fetch_err, exec_err, abr_q}
  function automatic logic [8:0] ex(input logic req, input logic lat, input logic xs,
                                    input logic [1:0] inc, input logic aq);
    return {req, lat, xs, inc, 1'b0, 1'b0, 1'b0, aq};
  endfunction

  function automatic logic [8:0] outs();
    return {imem_req, instr_latch_en, exec_start, pc_inc_type, halted, fetch_err, exec_err,
            abr_q};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input logic st, input logic ack, input logic [1:0] cls,
                       input logic done, input logic abr);
    @(negedge clk_i);
    stall = st; imem_ack = ack; instr_class = cls; exec_done = done; alu_br = abr;
    #1;
  endtask

  task automatic idle_cycle();
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; imem_ack = 1'b0; instr_class = 2'd0; exec_done = 1'b0; alu_br = 1'b0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    //            st ack cls  done abr  req lat xs inc aq   pc
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 0, H, 0), PcStart});          // IDLE
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(1, 0, 0, H, 0), PcStart});          // FETCH, no ack
    vq.push_back('{0, 1, 2'd0, 0, 0, ex(1, 1, 0, H, 0), PcStart});          // FETCH, ack
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 1, H, 0), PcStart});          // DECODE SEQ
    vq.push_back('{0, 0, 2'd0, 1, 0, ex(0, 0, 0, H, 0), PcStart});          // EXEC done
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 0, N, 0), PcStart});          // UPDATE
    vq.push_back('{0, 1, 2'd0, 0, 0, ex(1, 1, 0, H, 0), PcStart + 4});
    vq.push_back('{0, 0, 2'd1, 0, 0, ex(0, 0, 1, H, 0), PcStart + 4});      // DECODE BRANCH
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 0, H, 0), PcStart + 4});
    vq.push_back('{0, 0, 2'd0, 1, 1, ex(0, 0, 0, H, 0), PcStart + 4});      // done, taken
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 0, B, 1), PcStart + 4});
    vq.push_back('{0, 1, 2'd0, 0, 0, ex(1, 1, 0, H, 1), BrAddr});
    vq.push_back('{0, 0, 2'd1, 0, 0, ex(0, 0, 1, H, 1), BrAddr});
    vq.push_back('{0, 0, 2'd0, 1, 0, ex(0, 0, 0, H, 1), BrAddr});           // done, not taken
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 0, B, 0), BrAddr});
    vq.push_back('{0, 1, 2'd0, 0, 0, ex(1, 1, 0, H, 0), BrAddr + 4});
    vq.push_back('{0, 0, 2'd2, 0, 0, ex(0, 0, 1, H, 0), BrAddr + 4});       // DECODE JUMP
    vq.push_back('{0, 0, 2'd0, 1, 0, ex(0, 0, 0, H, 0), BrAddr + 4});
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 0, J, 0), BrAddr + 4});
    vq.push_back('{1, 0, 2'd0, 0, 0, ex(1, 0, 0, H, 0), JmpAddr});          // stalled FETCH
    vq.push_back('{1, 1, 2'd0, 0, 0, ex(1, 0, 0, H, 0), JmpAddr});          // ack lost
    vq.push_back('{0, 1, 2'd0, 0, 0, ex(1, 1, 0, H, 0), JmpAddr});
    vq.push_back('{1, 0, 2'd0, 0, 0, ex(0, 0, 0, H, 0), JmpAddr});          // stalled DECODE
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 1, H, 0), JmpAddr});
    vq.push_back('{1, 0, 2'd0, 1, 0, ex(0, 0, 0, H, 0), JmpAddr});          // done lost
    vq.push_back('{0, 0, 2'd0, 1, 0, ex(0, 0, 0, H, 0), JmpAddr});
    vq.push_back('{1, 0, 2'd0, 0, 0, ex(0, 0, 0, H, 0), JmpAddr});          // UPDATE stalled x3
    vq.push_back('{1, 0, 2'd0, 0, 0, ex(0, 0, 0, H, 0), JmpAddr});
    vq.push_back('{1, 0, 2'd0, 0, 0, ex(0, 0, 0, H, 0), JmpAddr});
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(0, 0, 0, N, 0), JmpAddr});
    vq.push_back('{0, 0, 2'd0, 0, 0, ex(1, 0, 0, H, 0), JmpAddr + 4});

    // Reset values while held in reset
    #12;
    check("reset_outputs", 32'(outs()), 32'(ex(0, 0, 0, H, 0)));

    do_reset();
    foreach (vq[i]) begin
      apply(vq[i].st, vq[i].ack, vq[i].cls, vq[i].done, vq[i].abr);
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vq[i].exp));
      check($sformatf("vec%0d_pc", i), pc, vq[i].pc);
    end
`ifdef PC_SEQ_PERF_EN
    check("retired_cnt", retired_cnt, 32'd5);
    check("taken_cnt", taken_cnt, 32'd2);
`endif

    // Fetch timeout, terminal ERR, then reset recovery
    do_reset();
    idle_cycle();
    for (int k = 0; k < 16; k++) idle_cycle();
    check("fetch_16th_req", 32'(imem_req), 32'd1);
    check("fetch_16th_err", 32'(fetch_err), 32'd0);
    idle_cycle();
    check("fetch_to_err", 32'(fetch_err), 32'd1);
    check("fetch_to_req", 32'(imem_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
      check("err_hold_inc", 32'(pc_inc_type), 32'(H));
      check("err_sticky", 32'(fetch_err), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("err_async_clear", 32'(outs()), 32'(ex(0, 0, 0, H, 0)));
    do_reset();
    idle_cycle();
    check("recover_idle_req", 32'(imem_req), 32'd0);
    idle_cycle();
    check("recover_fetch_req", 32'(imem_req), 32'd1);

    // Ack on the timeout cycle wins
    do_reset();
    idle_cycle();
    for (int k = 0; k < 15; k++) idle_cycle();
    apply(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("ack_at_timeout_latch", 32'(instr_latch_en), 32'd1);
    idle_cycle();
    check("ack_at_timeout_start", 32'(exec_start), 32'd1);
    check("ack_at_timeout_noerr", 32'(fetch_err), 32'd0);

    // Stall freezes the fetch timer
    do_reset();
    idle_cycle();
    for (int k = 0; k < 15; k++) idle_cycle();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      check("stall_req_level", 32'(imem_req), 32'd1);
    end
    idle_cycle();
    check("stall_timer_frozen", 32'(fetch_err), 32'd0);
    idle_cycle();
    check("stall_timer_expire", 32'(fetch_err), 32'd1);

    // Exec timeout
    do_reset();
    idle_cycle();
    apply(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    idle_cycle();
    for (int k = 0; k < 8; k++) idle_cycle();
    check("exec_8th_noerr", 32'(exec_err), 32'd0);
    idle_cycle();
    check("exec_to_err", 32'(exec_err), 32'd1);
    apply(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    check("exec_err_terminal", 32'({imem_req, pc_inc_type, exec_err}), 32'({1'b0, H, 1'b1}));

    // Done on the EXEC_MAX cycle wins
    do_reset();
    idle_cycle();
    apply(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    idle_cycle();
    for (int k = 0; k < 7; k++) idle_cycle();
    apply(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle_cycle();
    check("done_at_max_update", 32'(pc_inc_type), 32'(N));
    check("done_at_max_noerr", 32'(exec_err), 32'd0);

    // HALT is terminal
    do_reset();
    idle_cycle();
    apply(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    check("halt_no_start", 32'(exec_start), 32'd0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
      check("halt_state", 32'({halted, imem_req, pc_inc_type}), 32'({1'b1, 1'b0, H}));
    end

    // Async reset mid-FETCH drops imem_req without a clock edge
    do_reset();
    idle_cycle();
    idle_cycle();
    check("pre_reset_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_fetch", 32'(imem_req), 32'd0);

    // Async reset mid-EXEC and mid-UPDATE
    do_reset();
    idle_cycle();
    apply(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    idle_cycle();
    check("pre_reset_update", 32'({pc_inc_type, abr_q}), 32'({B, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("async_reset_update", 32'(outs()), 32'(ex(0, 0, 0, H, 0)));
`ifdef PC_SEQ_PERF_EN
    check("async_reset_perf", retired_cnt | taken_cnt, 32'd0);
`endif
    do_reset();
    idle_cycle();
    apply(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    rst_n = 1'b0;
    #1;
    check("async_reset_exec", 32'(outs()), 32'(ex(0, 0, 0, H, 0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
